// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin, packet-locked arbiter sharing the UART TX FIFO push
//             port between two byte sources, throttled against FIFO occupancy.
//  Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5,
  parameter int HOLD_MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  input  logic [CNT_W-1:0] tf_count,
  input  logic             flush,
  output logic             tf_push,
  output logic [7:0]       tf_data,
  output logic [1:0]       grant,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [7:0]     HOLD_LAST   = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] hold_q, hold_d;
  logic       tf_push_q, tf_push_d;
  logic [7:0] tf_data_q, tf_data_d;
  logic       timeout_q, timeout_d;

  logic [CNT_W:0] occupancy;
  logic           room;
  logic           own0, own1;
  logic           cur_valid, cur_last, cur_xfer;
  logic [7:0]     cur_data;

  // The push issued last cycle is not yet reflected in tf_count.
  assign occupancy = {1'b0, tf_count} + {{CNT_W{1'b0}}, tf_push_q};
  assign room      = occupancy < DEPTH_LIMIT;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  assign req0_ready = own0 && !flush && room;
  assign req1_ready = own1 && !flush && room;

  assign cur_valid = own1 ? req1_valid : req0_valid;
  assign cur_last  = own1 ? req1_last  : req0_last;
  assign cur_data  = own1 ? req1_data  : req0_data;
  assign cur_xfer  = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    tf_push_d    = 1'b0;
    tf_data_d    = tf_data_q;
    timeout_d    = 1'b0;

    if (flush) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          hold_d = '0;
          if (req0_valid && req1_valid) begin
            state_d = last_owner_q ? OWN0 : OWN1;
          end else if (req0_valid) begin
            state_d = OWN0;
          end else if (req1_valid) begin
            state_d = OWN1;
          end
        end
        OWN0, OWN1: begin
          if (cur_xfer) begin
            tf_push_d = 1'b1;
            tf_data_d = cur_data;
            hold_d    = '0;
            if (cur_last) begin
              state_d      = IDLE;
              last_owner_d = own1;
            end
          end else if (!cur_valid) begin
            // A FIFO-full stall keeps valid high and so never ages the lock.
            if (hold_q == HOLD_LAST) begin
              state_d      = IDLE;
              last_owner_d = own1;
              timeout_d    = 1'b1;
              hold_d       = '0;
            end else begin
              hold_d = hold_q + 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_q       <= '0;
      tf_push_q    <= 1'b0;
      tf_data_q    <= 8'h00;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      tf_push_q    <= tf_push_d;
      tf_data_q    <= tf_data_d;
      timeout_q    <= timeout_d;
    end
  end

  assign tf_push = tf_push_q;
  assign tf_data = tf_data_q;
  assign timeout = timeout_q;
  assign grant   = {own1, own0};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Scoreboard bench for uart_tx_arbiter: directed scenarios plus
//             randomized two-requester traffic against a packet-level model.
//  Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 5;
  localparam int HOLD_MAX   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req0_last = 1'b0;
  logic [7:0]       req0_data = 8'h00;
  logic             req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0]       req1_data = 8'h00;
  logic             flush = 1'b0;
  logic             req0_ready, req1_ready, tf_push, timeout;
  logic [7:0]       tf_data;
  logic [1:0]       grant;
  logic [CNT_W-1:0] tf_count;
  logic [CNT_W-1:0] cnt_dir = '0;
  logic             auto_fifo = 1'b0;
  int               fcnt = 0;
  int               done = 0;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] pushed[$];

  always #5 clk = ~clk;

  // Emulated transmitter FIFO: registers the push at the edge, drains randomly.
  always @(posedge clk) begin
    if (!auto_fifo) fcnt <= 0;
    else fcnt <= fcnt + int'(tf_push) - ((fcnt > 0 && $urandom_range(0, 2) == 0) ? 1 : 0);
  end
  assign tf_count = auto_fifo ? CNT_W'(fcnt) : cnt_dir;

  uart_tx_arbiter #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W),
    .HOLD_MAX  (HOLD_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_last (req0_last),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_last (req1_last),
    .req1_ready(req1_ready),
    .tf_count  (tf_count),
    .flush     (flush),
    .tf_push   (tf_push),
    .tf_data   (tf_data),
    .grant     (grant),
    .timeout   (timeout)
  );

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int take_stream();
    int v = 0;
    foreach (pushed[i]) v = (v << 8) | int'(pushed[i]);
    pushed.delete();
    return v;
  endfunction

  // Monitor and packet-level model: grant/timeout/ready rules and push ordering.
  logic [1:0] p_grant = 2'b00;
  logic       p_v0 = 1'b0, p_v1 = 1'b0, p_flush = 1'b0, p_acc = 1'b0, p_last = 1'b0;
  logic       lo = 1'b1;
  logic       exp_to = 1'b0;
  int         idle_run = 0;

  always @(negedge clk) begin : obs
    logic [1:0] eg;
    logic       a0, a1, room, own_v;
    if (!rst_n) begin
      sb.delete();
      p_grant = 2'b00; p_v0 = 1'b0; p_v1 = 1'b0; p_flush = 1'b0;
      p_acc = 1'b0; p_last = 1'b0; lo = 1'b1; exp_to = 1'b0; idle_run = 0;
    end else begin
      if (p_grant == 2'b00) begin
        if (p_flush)          eg = 2'b00;
        else if (p_v0 && p_v1) eg = lo ? 2'b01 : 2'b10;
        else if (p_v0)        eg = 2'b01;
        else if (p_v1)        eg = 2'b10;
        else                  eg = 2'b00;
      end else begin
        eg = (p_flush || p_last || exp_to) ? 2'b00 : p_grant;
      end
      check("grant", grant, eg);
      check("timeout", timeout, exp_to);
      check("tf_push", tf_push, p_acc);
      if (tf_push) begin
        if (sb.size() == 0) check("sb_underflow", tf_push, 0);
        else begin
          check("tf_data", tf_data, sb.pop_front());
          pushed.push_back(tf_data);
        end
      end
      room = (int'(tf_count) + int'(tf_push)) < FIFO_DEPTH;
      check("req0_ready", req0_ready, eg == 2'b01 && !flush && room);
      check("req1_ready", req1_ready, eg == 2'b10 && !flush && room);
      if (auto_fifo) check("fifo_overrun", int'(fcnt > FIFO_DEPTH), 0);

      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) sb.push_back(req0_data);
      if (a1) sb.push_back(req1_data);

      exp_to = 1'b0;
      if (eg != 2'b00 && !flush) begin
        own_v = (eg == 2'b01) ? req0_valid : req1_valid;
        if (a0 || a1) idle_run = 0;
        else if (!own_v) idle_run++;
        if (idle_run == HOLD_MAX) begin
          exp_to   = 1'b1;
          idle_run = 0;
        end
      end else begin
        idle_run = 0;
      end
      p_last = (a0 && req0_last) || (a1 && req1_last);
      if (exp_to || p_last) lo = (eg == 2'b10);
      p_grant = eg; p_v0 = req0_valid; p_v1 = req1_valid;
      p_flush = flush; p_acc = a0 || a1;
    end
  end

  task automatic drive_byte(input int r, input logic [7:0] d, input logic l, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    if (r == 0) begin req0_valid = 1'b1; req0_data = d; req0_last = l; end
    else        begin req1_valid = 1'b1; req1_data = d; req1_last = l; end
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      waited++;
      ok = (r == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
    end
    if (!ok) check("accept_bound", int'(ok), 1);
    @(posedge clk); #1;
    if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic send2(input int r, input logic [7:0] d0, input logic [7:0] d1);
    int w;
    drive_byte(r, d0, 1'b0, w);
    drive_byte(r, d1, 1'b1, w);
  endtask

  task automatic rand_drv(input int r, input int npkt);
    int w;
    for (int p = 0; p < npkt; p++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
        end
        drive_byte(r, 8'($urandom), b == len - 1, w);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pushed.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset state
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_push", tf_push, 0);
    check("rst_timeout", timeout, 0);
    check("rst_data", tf_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single packet, latency and end-of-packet release
    req0_valid = 1'b1; req0_data = 8'h41; req0_last = 1'b0;
    @(negedge clk);
    check("t1_idle_ready", req0_ready, 0);
    drive_byte(0, 8'h41, 1'b0, w);
    check("t1_latency", w, 1);
    check("t1_grant_mid", grant, 2'b01);
    drive_byte(0, 8'h42, 1'b0, w);
    drive_byte(0, 8'h43, 1'b1, w);
    check("t1_grant_end", grant, 2'b00);
    repeat (2) @(negedge clk);
    check("t1_len", pushed.size(), 3);
    check("t1_stream", take_stream(), 32'h00414243);

    // Contention after reset, twice
    do_reset();
    fork
      send2(0, 8'hA0, 8'hA1);
      send2(1, 8'hB0, 8'hB1);
    join
    repeat (2) @(negedge clk);
    check("t2a_len", pushed.size(), 4);
    check("t2a_stream", take_stream(), 32'hA0A1B0B1);
    @(posedge clk); #1;
    fork
      send2(0, 8'hC0, 8'hC1);
      send2(1, 8'hD0, 8'hD1);
    join
    repeat (2) @(negedge clk);
    check("t2b_len", pushed.size(), 4);
    check("t2b_stream", take_stream(), 32'hC0C1D0D1);

    // FIFO throttle
    @(posedge clk); #1;
    cnt_dir = 5'd15;
    req1_valid = 1'b1; req1_data = 8'h60; req1_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t3_ready_first", req1_ready, 1);
    @(posedge clk); #1;
    req1_data = 8'h61;
    @(negedge clk);
    check("t3_ready_push", req1_ready, 0);
    @(posedge clk); #1;
    cnt_dir = 5'd16;
    repeat (3) begin
      @(negedge clk);
      check("t3_ready_full", req1_ready, 0);
    end
    @(posedge clk); #1;
    cnt_dir = 5'd14;
    @(negedge clk);
    check("t3_ready_back", req1_ready, 1);
    @(posedge clk); #1;
    cnt_dir = 5'd0;
    drive_byte(1, 8'h62, 1'b1, w);
    repeat (2) @(negedge clk);
    check("t3_len", pushed.size(), 3);
    check("t3_stream", take_stream(), 32'h00606162);

    // Hold timeout with a pending competitor
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_data = 8'h80; req1_last = 1'b1;
    drive_byte(0, 8'h70, 1'b0, w);
    for (int i = 0; i < HOLD_MAX; i++) begin
      @(negedge clk);
      check("t4_hold_grant", grant, 2'b01);
      check("t4_hold_to", timeout, 0);
    end
    @(negedge clk);
    check("t4_timeout", timeout, 1);
    check("t4_released", grant, 2'b00);
    @(negedge clk);
    check("t4_to_pulse", timeout, 0);
    check("t4_next_owner", grant, 2'b10);
    check("t4_req1_ready", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_stream", take_stream(), 32'h00007080);

    // Flush mid-packet coinciding with a transfer attempt
    @(posedge clk); #1;
    drive_byte(1, 8'h90, 1'b0, w);
    req1_valid = 1'b1; req1_data = 8'h91; req1_last = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("t5_ready_flush", req1_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("t5_push", tf_push, 0);
    check("t5_grant", grant, 2'b00);
    check("t5_len", pushed.size(), 1);
    check("t5_stream", take_stream(), 32'h00000090);

    // Asynchronous reset while a push is on the port
    @(posedge clk); #1;
    drive_byte(0, 8'hA5, 1'b0, w);
    check("t6_push_before", tf_push, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_push", tf_push, 0);
    check("t6_grant", grant, 2'b00);
    check("t6_timeout", timeout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pushed.delete();

    // Randomized traffic with emulated FIFO and sporadic flushes
    auto_fifo = 1'b1;
    done = 0;
    fork
      begin rand_drv(0, 25); done++; end
      begin rand_drv(1, 25); done++; end
      begin
        while (done < 2) begin
          @(posedge clk); #1;
          flush = ($urandom_range(0, 39) == 0);
        end
        flush = 1'b0;
      end
    join
    auto_fifo = 1'b0;
    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
